// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared constants and types for the RedMulE TCDM splitter
package redmule_pkg;

    localparam int unsigned MemDw            = 32;
    localparam int unsigned SPLIT_FIFO_DEPTH = 2;

    typedef logic [MemDw-1:0] resp_word_t;

endpackage

// File: rtl/redmule_split_resp_fifo.sv
// rtl/redmule_split_resp_fifo.sv - 2-entry per-port response FIFO with empty-bypass
module redmule_split_resp_fifo
    import redmule_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  resp_word_t data_i,
    input  logic       pop_i,
    output resp_word_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    resp_word_t [SPLIT_FIFO_DEPTH-1:0] mem_q, mem_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       bypass, do_push, do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    // An empty FIFO hands the incoming word straight to the reader.
    assign data_o  = empty_o ? data_i : mem_q[rd_ptr_q];

    always_comb begin
        bypass   = empty_o & push_i & pop_i;
        do_push  = push_i & ~bypass & (~full_o | pop_i);
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = data_i;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/redmule_tcdm_splitter.sv
// rtl/redmule_tcdm_splitter.sv - skew-tolerant wide HCI to MP x 32-bit TCDM splitter
// Optional registered response path: REDMULE_TCDM_SPLIT_RESP_REG_EN.
module redmule_tcdm_splitter
    import redmule_pkg::*;
#(
    parameter int unsigned DW = 128,
    parameter int unsigned MP = DW / MemDw
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    input  logic [DW/8-1:0]       be_i,
    input  logic [DW-1:0]         data_i,
    output logic [DW-1:0]         r_data_o,
    output logic                  r_valid_o,
    output logic                  err_o,
    output logic [MP-1:0]         tcdm_req_o,
    input  logic [MP-1:0]         tcdm_gnt_i,
    output logic [MP-1:0][31:0]   tcdm_add_o,
    output logic [MP-1:0]         tcdm_wen_o,
    output logic [MP-1:0][3:0]    tcdm_be_o,
    output logic [MP-1:0][31:0]   tcdm_data_o,
    input  logic [MP-1:0][31:0]   tcdm_r_data_i,
    input  logic [MP-1:0]         tcdm_r_valid_i
);

    logic [MP-1:0]      granted_q, granted_d;
    logic [MP-1:0][1:0] pend_q, pend_d;
    logic               err_q, err_d;
    logic [MP-1:0]      rv_ok, fifo_full, fifo_empty, part_valid;
    logic [DW-1:0]      fifo_data;
    logic               wide_valid;

    always_comb begin
        for (int i = 0; i < MP; i++) begin
            tcdm_req_o[i]  = req_i & ~granted_q[i];
            tcdm_add_o[i]  = add_i + 32'(4 * i);
            tcdm_wen_o[i]  = wen_i;
            tcdm_be_o[i]   = be_i[4*i +: 4];
            tcdm_data_o[i] = data_i[32*i +: 32];
        end
    end

    assign gnt_o     = req_i & (&(granted_q | tcdm_gnt_i));
    assign granted_d = gnt_o ? '0 : (granted_q | (tcdm_gnt_i & tcdm_req_o));

    // Narrow responses only count while a read is outstanding on that port.
    always_comb begin
        for (int i = 0; i < MP; i++) begin
            rv_ok[i]  = tcdm_r_valid_i[i] & (pend_q[i] != 2'd0);
            pend_d[i] = pend_q[i] + 2'(tcdm_req_o[i] & tcdm_gnt_i[i] & wen_i) - 2'(rv_ok[i]);
`ifdef REDMULE_TCDM_SPLIT_RESP_REG_EN
            part_valid[i] = ~fifo_empty[i];
`else
            part_valid[i] = ~fifo_empty[i] | rv_ok[i];
`endif
        end
    end

    assign wide_valid = &part_valid;
    assign err_d = err_q | (|(tcdm_r_valid_i & ~rv_ok))
                         | (|(rv_ok & fifo_full & ~{MP{wide_valid}}));

    for (genvar g = 0; g < MP; g++) begin : g_fifo
        redmule_split_resp_fifo u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (rv_ok[g]),
            .data_i  (tcdm_r_data_i[g]),
            .pop_i   (wide_valid),
            .data_o  (fifo_data[32*g +: 32]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

`ifdef REDMULE_TCDM_SPLIT_RESP_REG_EN
    logic          r_valid_q, r_valid_d;
    logic [DW-1:0] r_data_q, r_data_d;

    always_comb begin
        r_valid_d = wide_valid;
        r_data_d  = wide_valid ? fifo_data : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;
`else
    assign r_valid_o = wide_valid;
    assign r_data_o  = wide_valid ? fifo_data : '0;
`endif

    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            granted_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            granted_q <= granted_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

endmodule
